// File: rtl/n_term_loopback_sm_pkg.sv
// Shared types for the north-edge terminal loopback switch matrix.
// Optional build macro: TERM_REG_LOOPBACK_EN (registers every looped-back output).
package term_sm_pkg;

  // Per-output route mode, two config bits per output.
  typedef enum logic [1:0] {
    RM_MIRROR   = 2'd0,
    RM_STRAIGHT = 2'd1,
    RM_ZERO     = 2'd2,
    RM_ONE      = 2'd3
  } route_mode_e;

  // Serial configuration loader state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } cfg_state_e;

  // Select one output bit from its mirror source, straight source or a constant.
  function automatic logic route_bit(input route_mode_e m, input logic mirror_bit,
                                     input logic straight_bit);
    case (m)
      RM_MIRROR:   return mirror_bit;
      RM_STRAIGHT: return straight_bit;
      RM_ZERO:     return 1'b0;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/n_term_loopback_sm_route_group.sv
// One wire group of the loopback matrix: routes an input bus to an output bus,
// each output bit picking mirror / straight / const0 / const1 from 2 mode bits.
// With TERM_REG_LOOPBACK_EN the output is registered and resets to 0.
module term_route_group
  import term_sm_pkg::*;
#(
  parameter int W = 4
) (
`ifdef TERM_REG_LOOPBACK_EN
  input  logic           clk,
  input  logic           rst_n,
`endif
  input  logic [W-1:0]   src,
  input  logic [2*W-1:0] mode,
  output logic [W-1:0]   dst
);

  logic [W-1:0] route_d;

  // Per-bit route selection; mirror takes the index-reversed input wire.
  always_comb begin
    route_d = '0;
    for (int k = 0; k < W; k++) begin
      route_d[k] = route_bit(route_mode_e'(mode[2*k +: 2]), src[W-1-k], src[k]);
    end
  end

`ifdef TERM_REG_LOOPBACK_EN
  // Output register: one cycle of latency, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dst <= '0;
    else        dst <= route_d;
  end
`else
  assign dst = route_d;
`endif

endmodule

// File: rtl/n_term_loopback_sm.sv
// North-edge terminal switch matrix: N-going wires looped back as S-going wires.
// Route modes load serially into a shadow register and are copied to the
// active register atomically on a commit from FULL, so routing never glitches.
// Optional build macro: TERM_REG_LOOPBACK_EN (registered S* outputs).
//
// Config interface: cfg_en shifts cfg_data (LSB of output 0 first) into the
// shadow on that clock edge; cfg_commit requests shadow->active on that edge.
// cfg_commit has priority over cfg_en (the data bit is dropped). A commit
// outside FULL is rejected and sets sticky cfg_err; a good commit clears it
// and pulses cfg_done for one cycle after the edge. cfg_state exposes the FSM.
module n_term_loopback_sm
  import term_sm_pkg::*;
#(
  parameter int W1  = 4,
  parameter int W2  = 8,
  parameter int W4  = 16,
  parameter int WN4 = 16
) (
  input  logic           UserCLK,
  input  logic           resetn,
  input  logic [W1-1:0]  N1END,
  input  logic [W2-1:0]  N2MID,
  input  logic [W2-1:0]  N2END,
  input  logic [W4-1:0]  N4END,
  input  logic [WN4-1:0] NN4END,
  output logic [W1-1:0]  S1BEG,
  output logic [W2-1:0]  S2BEG,
  output logic [W2-1:0]  S2BEGb,
  output logic [W4-1:0]  S4BEG,
  output logic [WN4-1:0] SS4BEG,
  input  logic           cfg_en,
  input  logic           cfg_data,
  input  logic           cfg_commit,
  output logic           cfg_done,
  output logic           cfg_err,
  output cfg_state_e     cfg_state
);

  localparam int NOUT     = W1 + 2*W2 + W4 + WN4;
  localparam int CFG_BITS = 2*NOUT;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

  // Config bit offsets of each output group inside the active register.
  localparam int O_S1  = 0;
  localparam int O_S2  = O_S1 + 2*W1;
  localparam int O_S2B = O_S2 + 2*W2;
  localparam int O_S4  = O_S2B + 2*W2;
  localparam int O_SS4 = O_S4 + 2*W4;

  cfg_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CFG_BITS-1:0] shadow_q, active_q;
  logic                shift_en, load_active;

  // Next-state logic: commit first, then shifting.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_en    = 1'b0;
    load_active = 1'b0;
    if (cfg_commit) begin
      state_d     = IDLE;
      count_d     = '0;
      load_active = (state_q == FULL);
    end else if (cfg_en) begin
      shift_en = 1'b1;
      case (state_q)
        SHIFT: begin
          count_d = count_q + 1'b1;
          if (count_d == CNT_FULL) state_d = FULL;
        end
        default: begin
          // IDLE or FULL: this bit starts a fresh load.
          state_d = SHIFT;
          count_d = CNT_W'(1);
        end
      endcase
    end
  end

  // FSM, count, shadow/active registers and status flags.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cfg_done <= load_active;
      if (shift_en)    shadow_q <= {cfg_data, shadow_q[CFG_BITS-1:1]};
      if (load_active) active_q <= shadow_q;
      if (cfg_commit)  cfg_err  <= (state_q != FULL);
    end
  end

  assign cfg_state = state_q;

  term_route_group #(.W(W1)) u_s1 (
`ifdef TERM_REG_LOOPBACK_EN
    .clk(UserCLK), .rst_n(resetn),
`endif
    .src(N1END), .mode(active_q[O_S1 +: 2*W1]), .dst(S1BEG)
  );

  term_route_group #(.W(W2)) u_s2 (
`ifdef TERM_REG_LOOPBACK_EN
    .clk(UserCLK), .rst_n(resetn),
`endif
    .src(N2MID), .mode(active_q[O_S2 +: 2*W2]), .dst(S2BEG)
  );

  term_route_group #(.W(W2)) u_s2b (
`ifdef TERM_REG_LOOPBACK_EN
    .clk(UserCLK), .rst_n(resetn),
`endif
    .src(N2END), .mode(active_q[O_S2B +: 2*W2]), .dst(S2BEGb)
  );

  term_route_group #(.W(W4)) u_s4 (
`ifdef TERM_REG_LOOPBACK_EN
    .clk(UserCLK), .rst_n(resetn),
`endif
    .src(N4END), .mode(active_q[O_S4 +: 2*W4]), .dst(S4BEG)
  );

  term_route_group #(.W(WN4)) u_ss4 (
`ifdef TERM_REG_LOOPBACK_EN
    .clk(UserCLK), .rst_n(resetn),
`endif
    .src(NN4END), .mode(active_q[O_SS4 +: 2*WN4]), .dst(SS4BEG)
  );

endmodule

// File: tb/tb_n_term_loopback_sm.sv
// Self-checking bench for n_term_loopback_sm at default sizes (52 outputs, 104 config bits).
// Optional build macro: TERM_REG_LOOPBACK_EN (bench expects one cycle of output latency).
module tb_n_term_loopback_sm;
  import term_sm_pkg::*;

  localparam int NB = 104;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  N1END = '0;
  logic [7:0]  N2MID = '0;
  logic [7:0]  N2END = '0;
  logic [15:0] N4END = '0;
  logic [15:0] NN4END = '0;
  logic [3:0]  S1BEG;
  logic [7:0]  S2BEG;
  logic [7:0]  S2BEGb;
  logic [15:0] S4BEG;
  logic [15:0] SS4BEG;
  logic        cfg_en = 1'b0;
  logic        cfg_data = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        cfg_done;
  logic        cfg_err;
  cfg_state_e  cfg_state;

  logic [51:0] dut_all;
  assign dut_all = {SS4BEG, S4BEG, S2BEGb, S2BEG, S1BEG};

  int n_checks = 0;
  int n_fail   = 0;

  logic [51:0] exp_q[$];

  // Bench-side reference of the config loader.
  logic [NB-1:0] m_shadow = '0;
  logic [NB-1:0] m_active = '0;
  int            m_state  = 0;   // 0 idle, 1 shift, 2 full
  int            m_count  = 0;
  logic          m_err    = 1'b0;

  n_term_loopback_sm dut (
    .UserCLK(clk), .resetn(resetn),
    .N1END(N1END), .N2MID(N2MID), .N2END(N2END), .N4END(N4END), .NN4END(NN4END),
    .S1BEG(S1BEG), .S2BEG(S2BEG), .S2BEGb(S2BEGb), .S4BEG(S4BEG), .SS4BEG(SS4BEG),
    .cfg_en(cfg_en), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .cfg_state(cfg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs for a packed input vector {NN4END,N4END,N2END,N2MID,N1END}.
  function automatic logic [51:0] model_out(input logic [NB-1:0] cfg, input logic [51:0] ins);
    int gb[5] = '{0, 4, 12, 20, 36};
    int gw[5] = '{4, 8, 8, 16, 16};
    logic [51:0] o = '0;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < gw[g]; k++) begin
        int j = gb[g] + k;
        logic [1:0] m = {cfg[2*j+1], cfg[2*j]};
        case (m)
          2'd0: o[j] = ins[gb[g] + gw[g] - 1 - k];
          2'd1: o[j] = ins[j];
          2'd2: o[j] = 1'b0;
          default: o[j] = 1'b1;
        endcase
      end
    end
    return o;
  endfunction

  // Driver: apply inputs, push expectation, sample and pop.
  task automatic drive_check(input string tag, input logic [51:0] ins);
    {NN4END, N4END, N2END, N2MID, N1END} = ins;
    exp_q.push_back(model_out(m_active, ins));
`ifdef TERM_REG_LOOPBACK_EN
    @(posedge clk); #1;
`else
    #1;
`endif
    check(tag, {12'h0, dut_all}, {12'h0, exp_q.pop_front()});
  endtask

  task automatic drive_random(input string tag, input int n);
    for (int i = 0; i < n; i++) drive_check(tag, 52'({$urandom(), $urandom()}));
  endtask

  task automatic shift_bits(input logic [NB-1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1;
      cfg_data = v[i];
      @(posedge clk); #1;
      m_shadow = {v[i], m_shadow[NB-1:1]};
      if (m_state == 1) begin
        m_count++;
        if (m_count == NB) m_state = 2;
      end else begin
        m_state = 1;
        m_count = 1;
      end
    end
    cfg_en = 1'b0;
    cfg_data = 1'b0;
  endtask

  task automatic commit(input string tag, input logic with_en);
    logic exp_done;
    exp_done = (m_state == 2);
    if (exp_done) m_active = m_shadow;
    m_err = !exp_done;
    m_state = 0;
    m_count = 0;
    cfg_commit = 1'b1;
    cfg_en = with_en;
    cfg_data = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    cfg_en = 1'b0;
    cfg_data = 1'b0;
    check({tag, "_done"}, 64'(cfg_done), 64'(exp_done));
    check({tag, "_err"}, 64'(cfg_err), 64'(m_err));
    check({tag, "_state"}, 64'(cfg_state), 64'(IDLE));
    @(posedge clk); #1;
    check({tag, "_done_clr"}, 64'(cfg_done), 64'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    resetn = 1'b0;
    m_shadow = '0; m_active = '0; m_state = 0; m_count = 0; m_err = 1'b0;
    @(posedge clk); #2;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Test 1: reset state and default mirror routing
    #2;
    check("rst_done", 64'(cfg_done), 64'h0);
    check("rst_err", 64'(cfg_err), 64'h0);
    check("rst_state", 64'(cfg_state), 64'(IDLE));
`ifdef TERM_REG_LOOPBACK_EN
    check("rst_out_zero", {12'h0, dut_all}, 64'h0);
`endif
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    drive_check("mirror_n4", {16'h0, 16'h0001, 8'h0, 8'h0, 4'b0011});
    check("mirror_s4", 64'(S4BEG), 64'h8000);
    check("mirror_s1", 64'(S1BEG), 64'hC);
    drive_random("mirror_rand", 4);

    // Test 2: straight everywhere
    shift_bits({52{2'b01}}, NB);
    check("full_state", 64'(cfg_state), 64'(FULL));
    commit("good1", 1'b0);
    drive_check("straight_n2", {16'h1234, 16'hBEEF, 8'h0F, 8'hC3, 4'b0110});
    check("straight_s2b", 64'(S2BEGb), 64'h0F);
    drive_random("straight_rand", 4);

    // Test 3: short load rejected, then good load accepted
    do_reset();
    shift_bits({52{2'b01}}, 50);
    check("short_state", 64'(cfg_state), 64'(SHIFT));
    commit("short", 1'b0);
    drive_random("short_keep_mirror", 3);
    shift_bits({52{2'b01}}, NB);
    commit("good2", 1'b0);
    drive_random("good2_rand", 3);

    // Test 4: commit together with the last data bit
    shift_bits({NB{1'b1}}, NB - 1);
    commit("collide", 1'b1);
    drive_random("collide_keep", 3);

    // Test 5: const0 everywhere, then reset in the middle of a reload
    shift_bits({52{2'b10}}, NB);
    commit("zero", 1'b0);
    drive_check("zero_ones", {52{1'b1}});
    drive_random("zero_rand", 2);
    {NN4END, N4END, N2END, N2MID, N1END} = 52'h0_0001_0000_0003;
    shift_bits({NB{1'b1}}, 40);
    #2;
    resetn = 1'b0;
    m_shadow = '0; m_active = '0; m_state = 0; m_count = 0; m_err = 1'b0;
    #1;
`ifdef TERM_REG_LOOPBACK_EN
    check("async_rst_out", {12'h0, dut_all}, 64'h0);
`else
    check("async_rst_out", {12'h0, dut_all}, {12'h0, model_out('0, 52'h0_0001_0000_0003)});
`endif
    check("async_rst_state", 64'(cfg_state), 64'(IDLE));
    check("async_rst_err", 64'(cfg_err), 64'h0);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    drive_random("post_rst_mirror", 3);
    commit("post_rst_bad", 1'b0);

`ifdef TERM_REG_LOOPBACK_EN
    // Test 6: registered output latency on the long quad group
    NN4END = 16'h0001;
    @(posedge clk); #1;
    NN4END = 16'h0100;
    #1;
    check("reg_hold", 64'(SS4BEG), 64'h8000);
    @(posedge clk); #1;
    check("reg_update", 64'(SS4BEG), 64'h0080);
`endif

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected 0 entries", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
